div_ctrl: RTL and testbench

EX-stage controller wrapping the existing 33-cycle iterative divider. It accepts one LoongArch `div.w/div.wu/mod.w/mod.wu` request from the EX issue logic and holds the divider's `div_en`, operands and sign mode stable for the full iteration. It samples quotient or remainder, then presents the result to MEM with a valid/ready handshake. It also stalls the pipeline and safely absorbs flushes while the divider cannot be aborted.

---
 rtl/div_pkg.sv | 36 +++
 rtl/div_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_div_ctrl.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// -----------------------------------------------------------------------------
// div_pkg: shared definitions for the EX-stage divider controller.
//   div_state_t      - controller FSM states
//   DIV_OP_MOD_BIT   - req_op bit selecting remainder (mod.w / mod.wu)
//   DIV_OP_UNS_BIT   - req_op bit selecting unsigned mode (div.wu / mod.wu)
//   DIV_CYCLES       - cycles div_en is held high (1 load + 32 iterations)
//   div_sel_result() - picks quotient or remainder from the divider outputs
// -----------------------------------------------------------------------------
package div_pkg;

  typedef enum logic [2:0] {
    DIV_IDLE  = 3'd0,
    DIV_RUN   = 3'd1,
    DIV_CAPT  = 3'd2,
    DIV_HOLD  = 3'd3,
    DIV_DRAIN = 3'd4
  } div_state_t;

  localparam int DIV_OP_MOD_BIT = 1;
  localparam int DIV_OP_UNS_BIT = 0;
  localparam int DIV_CYCLES     = 33;

  // Remainder for mod ops, quotient for div ops.
  function automatic logic [31:0] div_sel_result(input logic        is_mod,
                                                 input logic [31:0] quo,
                                                 input logic [31:0] rem);
    logic [31:0] res;
    if (is_mod) begin
      res = rem;
    end else begin
      res = quo;
    end
    return res;
  endfunction

endpackage : div_pkg

// File: rtl/div_ctrl.sv
// -----------------------------------------------------------------------------
// div_ctrl: EX-stage controller around the 33-cycle iterative divider.
// Accepts one div.w/div.wu/mod.w/mod.wu request, holds div_en/operands/sign
// mode stable for the whole iteration, captures quotient or remainder and
// offers it to MEM over a valid/ready handshake. Flushes are absorbed safely:
// a running divide cannot be aborted, so a flushed op drains to completion.
//
// Optional build macro: DIV_ZERO_FAST_EN - when defined, a request with a zero
// divisor skips the divider and produces its result one cycle after accept.
//
// Ports:
//   clk, rstn             core clock, async active-low reset
//   req_valid/req_ready   request handshake from EX issue
//   req_op                {is_mod, is_unsigned}
//   req_rd, req_x, req_y  destination register, dividend, divisor
//   flush                 kill the in-flight op
//   stall                 freeze EX input register (req_valid & ~req_ready)
//   div_en, div_x, div_y, div_signed  divider control / operands
//   div_quo, div_rem      divider results
//   res_valid/res_ready   result handshake to MEM
//   res_data, res_rd      selected result and destination register
// -----------------------------------------------------------------------------
module div_ctrl #(
  parameter int DIV_CYCLES = div_pkg::DIV_CYCLES
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_valid,
  input  logic [1:0]  req_op,
  input  logic [4:0]  req_rd,
  input  logic [31:0] req_x,
  input  logic [31:0] req_y,
  output logic        req_ready,
  input  logic        flush,
  output logic        stall,
  output logic        div_en,
  output logic [31:0] div_x,
  output logic [31:0] div_y,
  output logic        div_signed,
  input  logic [31:0] div_quo,
  input  logic [31:0] div_rem,
  output logic        res_valid,
  output logic [31:0] res_data,
  output logic [4:0]  res_rd,
  input  logic        res_ready
);

  import div_pkg::*;

  // Last RUN count and the count at which the divider has finished internally.
  localparam logic [5:0] CNT_LAST = 6'(DIV_CYCLES);
  localparam logic [5:0] CNT_END  = 6'(DIV_CYCLES + 1);

  div_state_t  state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] div_x_q, div_x_d;
  logic [31:0] div_y_q, div_y_d;
  logic        div_signed_q, div_signed_d;
  logic        is_mod_q, is_mod_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] res_data_q, res_data_d;
  logic [4:0]  res_rd_q, res_rd_d;
  logic        req_ready_q, req_ready_d;
  logic        div_en_q, div_en_d;
  logic        res_valid_q, res_valid_d;
  logic        accept_s;
  logic        capture_s;
  logic        zero_fast_s;

`ifdef DIV_ZERO_FAST_EN
  assign zero_fast_s = (req_y == 32'h0000_0000);
`else
  assign zero_fast_s = 1'b0;
`endif

  // FSM next state and iteration counter.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    accept_s  = 1'b0;
    capture_s = 1'b0;
    case (state_q)
      DIV_IDLE: begin
        // Flush wins over a simultaneous request.
        if (req_valid && !flush) begin
          accept_s = 1'b1;
          if (zero_fast_s) begin
            state_d = DIV_HOLD;
            cnt_d   = 6'd0;
          end else begin
            state_d = DIV_RUN;
            cnt_d   = 6'd1;
          end
        end else begin
          state_d = DIV_IDLE;
        end
      end
      DIV_RUN: begin
        cnt_d = cnt_q + 6'd1;
        if (flush) begin
          state_d = DIV_DRAIN;
        end else if (cnt_q == CNT_LAST) begin
          state_d = DIV_CAPT;
        end else begin
          state_d = DIV_RUN;
        end
      end
      DIV_CAPT: begin
        cnt_d = 6'd0;
        if (flush) begin
          state_d = DIV_IDLE;
        end else begin
          state_d   = DIV_HOLD;
          capture_s = 1'b1;
        end
      end
      DIV_HOLD: begin
        if (flush || res_ready) begin
          state_d = DIV_IDLE;
        end else begin
          state_d = DIV_HOLD;
        end
      end
      DIV_DRAIN: begin
        // The divider keeps iterating internally; wait until it is done.
        if (cnt_q == CNT_END) begin
          state_d = DIV_IDLE;
          cnt_d   = 6'd0;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      default: begin
        state_d = DIV_IDLE;
        cnt_d   = 6'd0;
      end
    endcase
  end

  // Operand/result datapath next values and registered output decode.
  always_comb begin
    div_x_d      = div_x_q;
    div_y_d      = div_y_q;
    div_signed_d = div_signed_q;
    is_mod_d     = is_mod_q;
    rd_d         = rd_q;
    res_data_d   = res_data_q;
    res_rd_d     = res_rd_q;
    if (accept_s) begin
      div_x_d      = req_x;
      div_y_d      = req_y;
      div_signed_d = ~req_op[DIV_OP_UNS_BIT];
      is_mod_d     = req_op[DIV_OP_MOD_BIT];
      rd_d         = req_rd;
      if (zero_fast_s) begin
        res_data_d = req_op[DIV_OP_MOD_BIT] ? req_x : 32'hFFFF_FFFF;
        res_rd_d   = req_rd;
      end else begin
        res_data_d = res_data_q;
      end
    end else if (capture_s) begin
      res_data_d = div_sel_result(is_mod_q, div_quo, div_rem);
      res_rd_d   = rd_q;
    end else begin
      res_data_d = res_data_q;
    end
    // Handshake/enable outputs are registered copies of the next-state decode.
    req_ready_d = (state_d == DIV_IDLE);
    div_en_d    = (state_d == DIV_RUN);
    res_valid_d = (state_d == DIV_HOLD);
  end

  // State, counter, operand and output registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= DIV_IDLE;
      cnt_q        <= 6'd0;
      div_x_q      <= 32'h0000_0000;
      div_y_q      <= 32'h0000_0000;
      div_signed_q <= 1'b0;
      is_mod_q     <= 1'b0;
      rd_q         <= 5'd0;
      res_data_q   <= 32'h0000_0000;
      res_rd_q     <= 5'd0;
      req_ready_q  <= 1'b1;
      div_en_q     <= 1'b0;
      res_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      div_x_q      <= div_x_d;
      div_y_q      <= div_y_d;
      div_signed_q <= div_signed_d;
      is_mod_q     <= is_mod_d;
      rd_q         <= rd_d;
      res_data_q   <= res_data_d;
      res_rd_q     <= res_rd_d;
      req_ready_q  <= req_ready_d;
      div_en_q     <= div_en_d;
      res_valid_q  <= res_valid_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign stall      = req_valid & ~req_ready_q;
  assign div_en     = div_en_q;
  assign div_x      = div_x_q;
  assign div_y      = div_y_q;
  assign div_signed = div_signed_q;
  assign res_valid  = res_valid_q;
  assign res_data   = res_data_q;
  assign res_rd     = res_rd_q;

endmodule : div_ctrl

// File: tb/tb_div_ctrl.sv
// -----------------------------------------------------------------------------
// tb_div_ctrl: self-checking bench for div_ctrl. A small behavioural divider
// stands in for the real peer instance: its outputs are only meaningful after
// exactly 33 consecutive div_en cycles, so an early or late capture shows up.
// -----------------------------------------------------------------------------
module tb_div_ctrl;

  logic        clk = 1'b0;
  logic        rstn;
  logic        req_valid;
  logic [1:0]  req_op;
  logic [4:0]  req_rd;
  logic [31:0] req_x, req_y;
  logic        req_ready;
  logic        flush;
  logic        stall;
  logic        div_en;
  logic [31:0] div_x, div_y;
  logic        div_signed;
  logic [31:0] div_quo, div_rem;
  logic        res_valid;
  logic [31:0] res_data;
  logic [4:0]  res_rd;
  logic        res_ready;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  div_ctrl dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_op(req_op), .req_rd(req_rd),
    .req_x(req_x), .req_y(req_y), .req_ready(req_ready),
    .flush(flush), .stall(stall),
    .div_en(div_en), .div_x(div_x), .div_y(div_y), .div_signed(div_signed),
    .div_quo(div_quo), .div_rem(div_rem),
    .res_valid(res_valid), .res_data(res_data), .res_rd(res_rd),
    .res_ready(res_ready)
  );

  // Behavioural divider: counts consecutive div_en cycles.
  int en_cnt;
  always @(posedge clk or negedge rstn) begin
    if (!rstn) en_cnt <= 0;
    else if (div_en) en_cnt <= en_cnt + 1;
    else en_cnt <= 0;
  end

  function automatic logic [63:0] model_div(input logic [31:0] x, input logic [31:0] y,
                                            input logic sgn);
    int sx, sy;
    logic [31:0] q, r;
    if (y == 32'h0) return {32'hFFFF_FFFF, x};
    if (sgn) begin
      if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'h8000_0000, 32'h0};
      sx = x; sy = y;
      q = sx / sy; r = sx % sy;
    end else begin
      q = x / y; r = x % y;
    end
    return {q, r};
  endfunction

  logic [63:0] model_s;
  assign model_s = model_div(div_x, div_y, div_signed);
  assign div_quo = (en_cnt == 33) ? model_s[63:32] : 32'hDEAD_BEEF;
  assign div_rem = (en_cnt == 33) ? model_s[31:0]  : 32'hBAAD_F00D;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    else n_pass++;
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (req_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_ready_wait"}, {31'd0, req_ready}, 32'd1);
  endtask

  // Drive one request at a negedge; returns just after the accepting edge.
  task automatic issue(input logic [1:0] op, input logic [4:0] rd,
                       input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_rd = rd; req_x = x; req_y = y;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  // Full operation with res_ready high; checks the 35-cycle timeline.
  task automatic run_op(input logic [1:0] op, input logic [4:0] rd, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] exp, input string tag);
    logic en_ok, opnd_ok, vld_ok;
    wait_ready(tag);
    issue(op, rd, x, y);
    en_ok = 1'b1; opnd_ok = 1'b1; vld_ok = 1'b1;
    for (int k = 1; k <= 34; k++) begin
      @(negedge clk);
      if (div_en !== (k <= 33)) en_ok = 1'b0;
      if (div_x !== x || div_y !== y || div_signed !== ~op[0]) opnd_ok = 1'b0;
      if (res_valid !== 1'b0) vld_ok = 1'b0;
    end
    @(negedge clk);
    check({tag, "_en_window"}, {31'd0, en_ok}, 32'd1);
    check({tag, "_operands"}, {31'd0, opnd_ok}, 32'd1);
    check({tag, "_early_valid"}, {31'd0, vld_ok}, 32'd1);
    check({tag, "_valid_c35"}, {31'd0, res_valid}, 32'd1);
    check({tag, "_data"}, res_data, exp);
    check({tag, "_rd"}, {27'd0, res_rd}, {27'd0, rd});
    @(negedge clk);
    check({tag, "_idle_after"}, {30'd0, req_ready, res_valid}, 32'd2);
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [4:0]  rd;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic en_ok, vld_ok, rdy34, rdy35;
    rstn = 1'b0; req_valid = 1'b0; req_op = 2'd0; req_rd = 5'd0;
    req_x = 32'h0; req_y = 32'h0; flush = 1'b0; res_ready = 1'b1;

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_ctrl", {28'd0, stall, div_en, div_signed, res_valid}, 32'd0);
    check("rst_div_x", div_x, 32'h0);
    check("rst_div_y", div_y, 32'h0);
    check("rst_res", res_data, 32'h0);
    check("rst_rd", {27'd0, res_rd}, 32'd0);
    rstn = 1'b1;

    vecs[0] = '{2'b00, 5'd1,  32'd100,       32'hFFFF_FFF9, 32'hFFFF_FFF2, "divw_100_m7"};
    vecs[1] = '{2'b10, 5'd2,  32'hFFFF_FF9C, 32'd7,         32'hFFFF_FFFE, "modw_m100_7"};
    vecs[2] = '{2'b00, 5'd3,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "divw_ovf"};
    vecs[3] = '{2'b10, 5'd4,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, "modw_ovf"};
    vecs[4] = '{2'b01, 5'd5,  32'hFFFF_FFFF, 32'd2,         32'h7FFF_FFFF, "divwu_max_2"};
    vecs[5] = '{2'b11, 5'd6,  32'hFFFF_FFF0, 32'd7,         32'h0000_0002, "modwu_big_7"};
    vecs[6] = '{2'b00, 5'd31, 32'hFFFF_FF9C, 32'd7,         32'hFFFF_FFF2, "divw_m100_7"};
    vecs[7] = '{2'b01, 5'd9,  32'd10,        32'd3,         32'd3,         "divwu_10_3"};
    for (int i = 0; i < 8; i++)
      run_op(vecs[i].op, vecs[i].rd, vecs[i].x, vecs[i].y, vecs[i].exp, vecs[i].name);

    // Result held while MEM back-pressures; queued request stalls.
    res_ready = 1'b0;
    wait_ready("hold");
    issue(2'b01, 5'd7, 32'hFFFF_FFFF, 32'd2);
    repeat (35) @(negedge clk);
    check("hold_valid_c35", {31'd0, res_valid}, 32'd1);
    check("hold_data_c35", res_data, 32'h7FFF_FFFF);
    req_valid = 1'b1; req_op = 2'b00; req_rd = 5'd8; req_x = 32'd9; req_y = 32'd3;
    #1 check("hold_stall_c35", {31'd0, stall}, 32'd1);
    for (int k = 36; k <= 38; k++) begin
      @(negedge clk);
      check("hold_stable", {res_valid, req_ready, stall, 24'd0, res_rd},
            {1'b1, 1'b0, 1'b1, 24'd0, 5'd7});
      check("hold_data", res_data, 32'h7FFF_FFFF);
    end
    res_ready = 1'b1;
    @(negedge clk);
    check("hold_release", {29'd0, req_ready, stall, res_valid}, 32'd4);
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (35) @(negedge clk);
    check("queued_valid", {31'd0, res_valid}, 32'd1);
    check("queued_data", res_data, 32'd3);
    check("queued_rd", {27'd0, res_rd}, 32'd8);
    @(negedge clk);

    // Flush in IDLE blocks the accept on that edge.
    req_valid = 1'b1; req_op = 2'b00; req_x = 32'd1; req_y = 32'd1; flush = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    check("flush_idle", {30'd0, req_ready, div_en}, 32'd2);

    // Flush at end of C10: drains to C34, idle in C35, no result.
    issue(2'b00, 5'd10, 32'd100, 32'd7);
    en_ok = 1'b1; vld_ok = 1'b1; rdy34 = 1'b1; rdy35 = 1'b0;
    for (int k = 1; k <= 35; k++) begin
      @(negedge clk);
      if (div_en !== (k <= 10)) en_ok = 1'b0;
      if (res_valid !== 1'b0) vld_ok = 1'b0;
      if (k == 34) rdy34 = req_ready;
      if (k == 35) rdy35 = req_ready;
      if (k == 10) begin
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
      end
    end
    check("flush_run_en", {31'd0, en_ok}, 32'd1);
    check("flush_run_novalid", {31'd0, vld_ok}, 32'd1);
    check("flush_run_rdy_c34", {31'd0, rdy34}, 32'd0);
    check("flush_run_rdy_c35", {31'd0, rdy35}, 32'd1);
    run_op(2'b00, 5'd11, 32'd9, 32'd3, 32'd3, "after_flush_9_3");

    // Flush in HOLD drops the result.
    res_ready = 1'b0;
    issue(2'b00, 5'd12, 32'd50, 32'd5);
    repeat (35) @(negedge clk);
    check("flush_hold_pre", {31'd0, res_valid}, 32'd1);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    check("flush_hold_post", {30'd0, req_ready, res_valid}, 32'd2);
    res_ready = 1'b1;

    // Reset during C20.
    issue(2'b00, 5'd13, 32'd77, 32'd7);
    repeat (20) @(negedge clk);
    rstn = 1'b0; req_valid = 1'b1;
    #1;
    check("midrst_req_ready", {31'd0, req_ready}, 32'd1);
    check("midrst_ctrl", {28'd0, stall, div_en, div_signed, res_valid}, 32'd0);
    check("midrst_div_x", div_x, 32'h0);
    check("midrst_res", res_data, 32'h0);
    check("midrst_rd", {27'd0, res_rd}, 32'd0);
    req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    run_op(2'b01, 5'd14, 32'd10, 32'd3, 32'd3, "after_rst_10_3");

`ifdef DIV_ZERO_FAST_EN
    // Zero divisor bypass: result in C1, divider never enabled.
    issue(2'b00, 5'd15, 32'd5, 32'd0);
    @(negedge clk);
    check("zf_div_c1", {30'd0, res_valid, div_en}, 32'd2);
    check("zf_div_data", res_data, 32'hFFFF_FFFF);
    @(negedge clk);
    check("zf_div_idle", {30'd0, req_ready, div_en}, 32'd2);
    issue(2'b10, 5'd16, 32'd5, 32'd0);
    @(negedge clk);
    check("zf_mod_c1", {30'd0, res_valid, div_en}, 32'd2);
    check("zf_mod_data", res_data, 32'd5);
    @(negedge clk);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_div_ctrl
